// File: rtl/logic_op_issuer_pkg.sv
// Shared constants and types for the logic-op issuer: opcodes, instruction
// field positions and FSM state encodings.
package logic_op_issuer_pkg;

  localparam int DATA_W = 16;

  // Instruction bit positions.
  localparam int BIT_COMPUTE = 15;
  localparam int BIT_OP_HI   = 10;
  localparam int BIT_OP_LO   = 9;
  localparam int BIT_SWAP    = 8;
  localparam int BIT_WR_A    = 5;
  localparam int BIT_WR_D    = 4;

  // Logic-unit operation select, presented as {lu_op1, lu_op0}.
  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOT = 2'b11
  } lu_op_e;

  // Issue FSM states.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    ISSUE     = 2'b01,
    WRITEBACK = 2'b10
  } state_e;

endpackage

// File: rtl/logic_instr_decode.sv
// Purely combinational decode of one 16-bit instruction word into its fields.
module logic_instr_decode
  import logic_op_issuer_pkg::*;
(
  input  logic [15:0]       instr_i,
  output logic              is_compute_o,
  output lu_op_e            op_o,
  output logic              swap_o,
  output logic              wr_a_o,
  output logic              wr_d_o,
  output logic [DATA_W-1:0] imm_o
);

  // Field extraction; load-immediate zero-extends the low 15 bits.
  always_comb begin
    is_compute_o = instr_i[BIT_COMPUTE];
    op_o         = lu_op_e'(instr_i[BIT_OP_HI:BIT_OP_LO]);
    swap_o       = instr_i[BIT_SWAP];
    wr_a_o       = instr_i[BIT_WR_A];
    wr_d_o       = instr_i[BIT_WR_D];
    imm_o        = {1'b0, instr_i[14:0]};
  end

endmodule

// File: rtl/logic_op_issuer.sv
// Issues logic instructions to an external combinational logic unit and
// writes its result back into the A/D registers. Load-immediates retire in
// the accept cycle; computes take IDLE -> ISSUE -> WRITEBACK.
module logic_op_issuer
  import logic_op_issuer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] lu_x,
  output logic [DATA_W-1:0] lu_y,
  output logic              lu_op1,
  output logic              lu_op0,
  input  logic [DATA_W-1:0] lu_out,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_d,
  output logic              done
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [DATA_W-1:0] y_q, y_d;
  lu_op_e            op_q, op_d;
  logic              wr_a_q, wr_a_d;
  logic              wr_d_q, wr_d_d;
  logic              done_q, done_d;

  logic              dec_is_compute;
  lu_op_e            dec_op;
  logic              dec_swap;
  logic              dec_wr_a;
  logic              dec_wr_d;
  logic [DATA_W-1:0] dec_imm;
  logic              accept;

  logic_instr_decode u_decode (
    .instr_i      (instr),
    .is_compute_o (dec_is_compute),
    .op_o         (dec_op),
    .swap_o       (dec_swap),
    .wr_a_o       (dec_wr_a),
    .wr_d_o       (dec_wr_d),
    .imm_o        (dec_imm)
  );

  assign instr_ready = (state_q == IDLE);
  assign accept      = instr_valid && instr_ready;

  // Next-state and datapath updates; operand/op registers hold when idle.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    a_d     = a_q;
    d_d     = d_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    wr_a_d  = wr_a_q;
    wr_d_d  = wr_d_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_is_compute) begin
            state_d = ISSUE;
            x_d     = dec_swap ? a_q : d_q;
            y_d     = dec_swap ? d_q : a_q;
            op_d    = dec_op;
            wr_a_d  = dec_wr_a;
            wr_d_d  = dec_wr_d;
          end else begin
            a_d    = dec_imm;
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        state_d = IDLE;
        if (wr_a_q) a_d = lu_out;
        if (wr_d_q) d_d = lu_out;
        done_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset wins over accept and writeback.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      d_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= OP_AND;
      wr_a_q  <= 1'b0;
      wr_d_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      d_q     <= d_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      wr_a_q  <= wr_a_d;
      wr_d_q  <= wr_d_d;
      done_q  <= done_d;
    end
  end

  assign lu_x   = x_q;
  assign lu_y   = y_q;
  assign lu_op1 = op_q[1];
  assign lu_op0 = op_q[0];
  assign reg_a  = a_q;
  assign reg_d  = d_q;
  assign done   = done_q;

endmodule

// File: tb/tb_logic_op_issuer.sv
// Scoreboard bench for logic_op_issuer: a monitor pushes the expected A/D and
// latency on every accept and pops/compares on every done pulse.
module tb_logic_op_issuer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [15:0] lu_x, lu_y, lu_out, reg_a, reg_d;
  logic        lu_op1, lu_op0;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_acc = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    int          lat;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] ma = '0;
  logic [15:0] md = '0;

  logic_op_issuer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .lu_x        (lu_x),
    .lu_y        (lu_y),
    .lu_op1      (lu_op1),
    .lu_op0      (lu_op0),
    .lu_out      (lu_out),
    .reg_a       (reg_a),
    .reg_d       (reg_d),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External logic unit.
  always_comb begin
    case ({lu_op1, lu_op0})
      2'b00:   lu_out = lu_x & lu_y;
      2'b01:   lu_out = lu_x | lu_y;
      2'b10:   lu_out = lu_x ^ lu_y;
      default: lu_out = ~lu_x;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_op(input logic [1:0] op, input logic [15:0] x, input logic [15:0] y);
    case (op)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] x, y, r;
    if (done) begin
      check("done_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("reg_a", reg_a, e.a);
        check("reg_d", reg_d, e.d);
        check("latency", cyc - e.cyc, e.lat);
      end
    end
    if (rst) begin
      sb.delete();
      ma = '0;
      md = '0;
    end else if (instr_valid && instr_ready) begin
      n_acc++;
      if (!instr[15]) begin
        ma = {1'b0, instr[14:0]};
        sb.push_back('{a: ma, d: md, lat: 1, cyc: cyc});
      end else begin
        x = instr[8] ? ma : md;
        y = instr[8] ? md : ma;
        r = ref_op(instr[10:9], x, y);
        if (instr[5]) ma = r;
        if (instr[4]) md = r;
        sb.push_back('{a: ma, d: md, lat: 3, cyc: cyc});
      end
    end
  end

  task automatic send(input logic [15:0] w);
    @(posedge clk);
    #1;
    instr_valid = 1'b1;
    instr       = w;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_ready) break;
    end
    check("accept_timeout", instr_ready, 1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic drive_cycle(input logic [15:0] w);
    @(posedge clk);
    #1;
    instr_valid = 1'b1;
    instr       = w;
  endtask

  task automatic release_valid();
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    int acc0;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    check("rst_ready", instr_ready, 1);
    check("rst_a", reg_a, 16'h0000);
    check("rst_d", reg_d, 16'h0000);
    check("rst_x", lu_x, 16'h0000);
    check("rst_y", lu_y, 16'h0000);
    check("rst_op", {lu_op1, lu_op0}, 2'b00);
    check("rst_done", done, 0);

    // Load-immediate.
    send(16'h00F0);
    wait_drain();
    check("li_a", reg_a, 16'h00F0);
    check("li_d", reg_d, 16'h0000);

    // Build D=0x0FF0, A=0x00F0, then AND into both.
    send(16'h0FF0);
    send(16'h8210);
    send(16'h00F0);
    wait_drain();
    check("setup_d", reg_d, 16'h0FF0);
    send(16'h8030);
    wait_drain();
    check("and_a", reg_a, 16'h00F0);
    check("and_d", reg_d, 16'h00F0);

    // Same operands again, NOT with swap into D only.
    send(16'h0FF0);
    send(16'h8210);
    send(16'h00F0);
    send(16'h8710);
    check("issue_x", lu_x, 16'h00F0);
    check("issue_y", lu_y, 16'h0FF0);
    check("issue_op", {lu_op1, lu_op0}, 2'b11);
    @(posedge clk);
    #1;
    check("wb_x", lu_x, 16'h00F0);
    wait_drain();
    check("not_d", reg_d, 16'hFF0F);
    check("not_a", reg_a, 16'h00F0);
    check("idle_hold_x", lu_x, 16'h00F0);
    check("idle_hold_op", {lu_op1, lu_op0}, 2'b11);

    // Reset during WRITEBACK of an XOR aborts it.
    send(16'h8420);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_ready", instr_ready, 1);
    check("abort_a", reg_a, 16'h0000);
    check("abort_d", reg_d, 16'h0000);
    check("abort_done", done, 0);
    @(negedge clk);
    check("abort_no_done", done, 0);

    // Valid held high with new words while busy.
    send(16'h0055);
    wait_drain();
    acc0 = n_acc;
    drive_cycle(16'h8720);
    drive_cycle(16'h0111);
    drive_cycle(16'h0222);
    drive_cycle(16'h0333);
    drive_cycle(16'h0444);
    release_valid();
    wait_drain();
    check("busy_accepts", n_acc - acc0, 3);
    check("busy_final_a", reg_a, 16'h0444);

    // Back-to-back load-immediates.
    for (int i = 1; i <= 4; i++) drive_cycle(16'(i));
    release_valid();
    wait_drain();
    check("b2b_final_a", reg_a, 16'h0004);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_op_issuer.md
LOGIC_OP_ISSUER -- requirements
Module: logic_op_issuer

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port: instr_valid  input  1  instruction word present.
REQ-004 SHALL have port: instr  input  16  instruction word.
REQ-005 SHALL have port: instr_ready  output  1  block accepts instr this cycle.
REQ-006 SHALL have port: lu_x  output  16  X operand to the external logic unit.
REQ-007 SHALL have port: lu_y  output  16  Y operand to the external logic unit.
REQ-008 SHALL have port: lu_op1  output  1  logic-unit op select, high bit.
REQ-009 SHALL have port: lu_op0  output  1  logic-unit op select, low bit.
REQ-010 SHALL have port: lu_out  input  16  combinational result returned by the logic unit.
REQ-011 SHALL have port: reg_a  output  16  current A register.
REQ-012 SHALL have port: reg_d  output  16  current D register.
REQ-013 SHALL have port: done  output  1  one-cycle pulse when an instruction retires.

Function
REQ-014 SHALL accept an instruction only on a clock edge where instr_valid=1 and instr_ready=1.
REQ-015 SHALL drive instr_ready = 1 only in state IDLE.
REQ-016 SHALL decode instr[15]=0 as load-immediate: A <= {1'b0, instr[14:0]}; D unchanged.
REQ-017 SHALL decode instr[15]=1 as compute:
- instr[10:9] = {op1,op0}: 00 AND, 01 OR, 10 XOR, 11 NOT X.
- instr[8] = swap: 0 gives X=D, Y=A; 1 gives X=A, Y=D.
- instr[5] = write A; instr[4] = write D.
- all other bits ignored.
REQ-018 SHALL implement FSM states IDLE, ISSUE and WRITEBACK.
REQ-019 SHALL transition IDLE->ISSUE on accept of a compute instruction.
REQ-020 SHALL transition ISSUE->WRITEBACK unconditionally.
REQ-021 SHALL transition WRITEBACK->IDLE unconditionally.
REQ-022 SHALL retire a load-immediate in the accept cycle: A updates at the accept edge, done=1 on the following cycle, state stays IDLE.
REQ-023 SHALL, for a compute instruction, capture decoded fields at the accept edge.
REQ-024 SHALL drive lu_x, lu_y, lu_op1 and lu_op0 from registers during ISSUE and WRITEBACK, and hold them stable across both cycles.
REQ-025 SHALL sample lu_out at the WRITEBACK edge into every selected destination.
REQ-026 SHALL, when both destinations are selected, write the same value to A and D.
REQ-027 SHALL, when no destination is selected, still retire normally.
REQ-028 SHALL have compute latency of 3 edges: accept at edge N, writeback at edge N+2, done=1 in cycle after N+2, instr_ready=1 in that same cycle.
REQ-029 SHALL hold lu_x, lu_y and lu_op* at their last value in IDLE.
REQ-030 SHALL ignore instr and instr_valid while not in IDLE; no instruction SHALL be lost or duplicated.
REQ-031 SHALL support back-to-back load-immediates at one per cycle.

Reset
REQ-032 SHALL, with rst=1 at an edge, set state=IDLE, A=0x0000, D=0x0000, lu_x=lu_y=0x0000, lu_op1=lu_op0=0, done=0; instr_ready SHALL be 1 in the cycle after reset.
REQ-033 SHALL give rst priority over accept and over writeback: reset in ISSUE or WRITEBACK aborts the instruction with no register write and no done pulse.

Structure
REQ-034 SHALL place opcode constants (OP_AND=00, OP_OR=01, OP_XOR=10, OP_NOT=11), instruction bit positions and FSM state encodings in a shared package.
REQ-035 SHALL isolate decode in one combinational sub-module, logic_instr_decode (instr -> is_compute, op, swap, wr_a, wr_d, imm).

Verification
REQ-036 SHALL check: reset, then instr=0x00F0 -> A=0x00F0, done pulses once, D=0x0000.
REQ-037 SHALL check: A=0x00F0, D=0x0FF0, instr=0x8030 (AND, swap=0, wr A+D), lu tied to the logic unit -> A=D=0x00F0 at edge N+2.
REQ-038 SHALL check: same operands, instr=0x8710 (NOT, swap=1, wr D) -> lu_x=0x00F0, D=0xFF0F, A unchanged.
REQ-039 SHALL check: instr_valid held high with new words during ISSUE/WRITEBACK -> exactly one accept per instr_ready cycle.
REQ-040 SHALL check: rst asserted in WRITEBACK of XOR instr 0x8420 -> A=D=0x0000, no done, instr_ready=1 next cycle.
REQ-041 SHALL check: four consecutive load-immediates 0x0001..0x0004 -> four done pulses on consecutive cycles, final A=0x0004.
